// File: rtl/mos_sched_pkg.sv
// Shared definitions for the serial MOSFET-calculator front end:
// FSM states, mode-bit positions, datapath widths and the frame weighting.
package mos_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int MODE_ID_BIT    = 0;
  localparam int MODE_LARGE_BIT = 1;

  localparam int VAL_W = 7;
  localparam int OUT_W = 8;

  // Weighted sums reach 12*84 = 1008, so 11 bits hold every intermediate.
  localparam int SUM_W = 11;

  localparam logic [SUM_W-1:0] WT_N0  = 11'd3;
  localparam logic [SUM_W-1:0] WT_N1  = 11'd4;
  localparam logic [SUM_W-1:0] WT_N2  = 11'd5;
  localparam logic [SUM_W-1:0] WT_DEN = 11'd12;
  localparam logic [SUM_W-1:0] GM_DEN = 11'd3;

  // Frame result from the three selected values (n0 >= n1 >= n2).
  function automatic logic [SUM_W-1:0] frame_result(
    input logic [SUM_W-1:0] n0,
    input logic [SUM_W-1:0] n1,
    input logic [SUM_W-1:0] n2,
    input logic             sel_id
  );
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] res;
    if (sel_id) begin
      sum = (WT_N0 * n0) + (WT_N1 * n1) + (WT_N2 * n2);
      res = sum / WT_DEN;
    end else begin
      sum = n0 + n1 + n2;
      res = sum / GM_DEN;
    end
    return res;
  endfunction

endpackage

// File: rtl/mos_eval_scheduler_if.sv
// Sample/result bus of the MOSFET evaluation scheduler.
// master = sample source / result sink, slave = scheduler.
interface mos_eval_scheduler_if #(
  parameter int OUT_W = mos_sched_pkg::OUT_W
);
  logic             in_valid;
  logic [1:0]       mode;
  logic [2:0]       W;
  logic [2:0]       V_GS;
  logic [2:0]       V_DS;
  logic             out_valid;
  logic [OUT_W-1:0] out_n;

  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  out_valid, out_n
  );

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output out_valid, out_n
  );
endinterface

// File: rtl/mos_eval.sv
// Combinational single-device MOSFET evaluator: returns floor(Id) or
// floor(gm) (both already scaled by 1/3) for one (W, V_GS, V_DS) triple.
module mos_eval #(
  parameter int VAL_W = mos_sched_pkg::VAL_W
) (
  input  logic [2:0]       W,
  input  logic [2:0]       V_GS,
  input  logic [2:0]       V_DS,
  input  logic             sel_id,
  output logic [VAL_W-1:0] result
);
  logic [11:0] ov;
  logic [11:0] vds;
  logic [11:0] wd;
  logic [11:0] id_num;
  logic [11:0] gm_num;
  logic [11:0] quot;

  // Region select (triode when overdrive exceeds V_DS) and scaled output.
  always_comb begin
    ov  = {9'd0, V_GS} - 12'd1;
    vds = {9'd0, V_DS};
    wd  = {9'd0, W};
    if (ov > vds) begin
      id_num = wd * ((12'd2 * ov * vds) - (vds * vds));
      gm_num = 12'd2 * wd * vds;
    end else begin
      id_num = wd * ov * ov;
      gm_num = 12'd2 * wd * ov;
    end
    if (sel_id) begin
      quot = id_num / 12'd3;
    end else begin
      quot = gm_num / 12'd3;
    end
  end

  assign result = VAL_W'(quot);
endmodule

// File: rtl/mos_eval_scheduler.sv
// Serial MOSFET-calculator front end: one evaluator shared across N_DEV
// devices, a descending insertion-sorted result list, one output per frame.
// Optional build macro MOS_EVAL_PIPE_EN registers the evaluator output
// before insertion (latency t+3 instead of t+2).
module mos_eval_scheduler #(
  parameter int N_DEV = 6,
  parameter int VAL_W = 7,
  parameter int OUT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  mos_eval_scheduler_if.slave bus
);
  import mos_sched_pkg::*;

  localparam int              CNT_W    = $clog2(N_DEV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DEV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_r;
  logic [VAL_W-1:0] s     [N_DEV];
  logic [VAL_W-1:0] base  [N_DEV];
  logic [VAL_W-1:0] s_nxt [N_DEV];
  logic             ge    [N_DEV];

  logic             sel_id;
  logic [VAL_W-1:0] eval_val;
  logic             start;
  logic             accept;
  logic             last;
  logic             abort;
  logic             calc_ready;
  logic             ins_en;
  logic [VAL_W-1:0] ins_val;

  logic [SUM_W-1:0] n0;
  logic [SUM_W-1:0] n1;
  logic [SUM_W-1:0] n2;
  logic [SUM_W-1:0] res;

  logic             out_valid_r;
  logic [OUT_W-1:0] out_n_r;

  assign start  = (state == IDLE) && bus.in_valid;
  assign accept = bus.in_valid && ((state == IDLE) || (state == LOAD));
  assign last   = (state == LOAD) && bus.in_valid && (cnt == CNT_LAST);
  assign abort  = (state == LOAD) && !bus.in_valid;

  // The first sample of a frame must use the incoming mode; mode_r is not yet loaded.
  assign sel_id = (state == IDLE) ? bus.mode[MODE_ID_BIT] : mode_r[MODE_ID_BIT];

  mos_eval #(.VAL_W(VAL_W)) u_eval (
    .W      (bus.W),
    .V_GS   (bus.V_GS),
    .V_DS   (bus.V_DS),
    .sel_id (sel_id),
    .result (eval_val)
  );

`ifdef MOS_EVAL_PIPE_EN
  logic             pipe_valid;
  logic [VAL_W-1:0] pipe_val;

  // Evaluator-to-insert pipe stage; flushed on abort so nothing leaks into the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      pipe_valid <= 1'b0;
      pipe_val   <= {VAL_W{1'b0}};
    end else begin
      pipe_valid <= accept;
      pipe_val   <= eval_val;
    end
  end

  assign ins_en     = pipe_valid;
  assign ins_val    = pipe_val;
  assign calc_ready = !pipe_valid;
`else
  assign ins_en     = accept;
  assign ins_val    = eval_val;
  assign calc_ready = 1'b1;
`endif

  // Stable descending insertion; a new frame starts from an all-zero list.
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      if (start) begin
        base[i] = {VAL_W{1'b0}};
      end else begin
        base[i] = s[i];
      end
      ge[i] = (base[i] >= ins_val);
    end
    if (!ins_en || ge[0]) begin
      s_nxt[0] = base[0];
    end else begin
      s_nxt[0] = ins_val;
    end
    for (int i = 1; i < N_DEV; i++) begin
      if (!ins_en || ge[i]) begin
        s_nxt[i] = base[i];
      end else if (ge[i-1]) begin
        s_nxt[i] = ins_val;
      end else begin
        s_nxt[i] = base[i-1];
      end
    end
  end

  // Sorted list register; reset and abort discard the frame.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      for (int i = 0; i < N_DEV; i++) begin
        s[i] <= {VAL_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_DEV; i++) begin
        s[i] <= s_nxt[i];
      end
    end
  end

  // Frame mode latch and device counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r <= 2'b00;
      cnt    <= {CNT_W{1'b0}};
    end else begin
      if (start) begin
        mode_r <= bus.mode;
      end else begin
        mode_r <= mode_r;
      end
      if (abort || (state == OUT)) begin
        cnt <= {CNT_W{1'b0}};
      end else if (start) begin
        cnt <= CNT_W'(1);
      end else if ((state == LOAD) && bus.in_valid) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (!bus.in_valid) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = CALC;
        end else begin
          state_nxt = LOAD;
        end
      end
      CALC: begin
        if (calc_ready) begin
          state_nxt = OUT;
        end else begin
          state_nxt = CALC;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the larger or smaller three of the sorted list and weight them.
  always_comb begin
    if (mode_r[MODE_LARGE_BIT]) begin
      n0 = SUM_W'(s[0]);
      n1 = SUM_W'(s[1]);
      n2 = SUM_W'(s[2]);
    end else begin
      n0 = SUM_W'(s[N_DEV-3]);
      n1 = SUM_W'(s[N_DEV-2]);
      n2 = SUM_W'(s[N_DEV-1]);
    end
    res = frame_result(n0, n1, n2, mode_r[MODE_ID_BIT]);
  end

  // Registered result strobe; out_n is forced to zero outside the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_n_r     <= {OUT_W{1'b0}};
    end else if ((state == CALC) && calc_ready) begin
      out_valid_r <= 1'b1;
      out_n_r     <= OUT_W'(res);
    end else begin
      out_valid_r <= 1'b0;
      out_n_r     <= {OUT_W{1'b0}};
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_n     = out_n_r;
endmodule
